writeback_retire_queue: RTL and testbench

//  In-order writeback/retire stage with a DEPTH-entry queue that decouples MEM-stage issue from variable-latency load data.
//  Non-load results and load responses retire strictly in program order, one per cycle, through a registered

---
 rtl/writeback_retire_queue.sv | 143 ++++++++++++++
 tb/tb_writeback_retire_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_retire_queue.sv
// In-order writeback/retire queue: buffers MEM-stage results, merges variable-latency load
// responses (byte/half extracted, sign/zero extended) and retires one entry per cycle to the register file.
module writeback_retire_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            rd_valid_in,
    input  logic [4:0]      rd_addr_in,
    input  logic [XLEN-1:0] rd_value_in,
    input  logic [5:0]      instr_id_in,
    input  logic [1:0]      addr_lo_in,
    input  logic            rsp_valid,
    output logic            rsp_ready,
    input  logic [XLEN-1:0] rsp_data,
    output logic            wr_en_out,
    output logic [4:0]      rd_addr_out,
    output logic [XLEN-1:0] rd_value_out,
    output logic            rsp_err
);

    localparam logic [5:0] INSTR_LB  = 6'd3;
    localparam logic [5:0] INSTR_LH  = 6'd4;
    localparam logic [5:0] INSTR_LW  = 6'd5;
    localparam logic [5:0] INSTR_LBU = 6'd6;
    localparam logic [5:0] INSTR_LHU = 6'd7;
    localparam int         PW        = $clog2(DEPTH);

    logic [DEPTH-1:0] e_is_load;
    logic [DEPTH-1:0] e_rd_valid;
    logic [DEPTH-1:0] e_done;
    logic [4:0]       e_rd_addr  [DEPTH];
    logic [XLEN-1:0]  e_value    [DEPTH];
    logic [5:0]       e_instr_id [DEPTH];
    logic [1:0]       e_addr_lo  [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    logic          is_load_in;
    logic          enq;
    logic          pop;
    logic          rsp_acc;
    logic          rsp_found;
    logic [PW-1:0] rsp_idx;
    logic [PW-1:0] scan_idx;
    logic [XLEN-1:0] ext_value;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [5:0]    rsp_id;
    logic [1:0]    rsp_lo;

    assign is_load_in = (instr_id_in == INSTR_LB)  || (instr_id_in == INSTR_LH)  ||
                        (instr_id_in == INSTR_LW)  || (instr_id_in == INSTR_LBU) ||
                        (instr_id_in == INSTR_LHU);

    // Ready comes from the registered count only, so a full queue stays closed even while popping.
    assign in_ready  = (count < (PW+1)'(DEPTH));
    assign enq       = in_valid && in_ready;
    assign pop       = (count != '0) && e_done[head];
    assign rsp_ready = rsp_found;
    assign rsp_acc   = rsp_valid && rsp_found;

    // Oldest still-pending load, scanned from the head over occupied slots.
    always_comb begin
        rsp_found = 1'b0;
        rsp_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PW'(i);
            if (!rsp_found && ((PW+1)'(i) < count) && e_is_load[scan_idx] && !e_done[scan_idx]) begin
                rsp_found = 1'b1;
                rsp_idx   = scan_idx;
            end
        end
    end

    assign rsp_id = e_instr_id[rsp_idx];
    assign rsp_lo = e_addr_lo[rsp_idx];
    assign byte_v = 8'(rsp_data >> {rsp_lo, 3'b000});
    assign half_v = 16'(rsp_data >> {rsp_lo[1], 4'b0000});

    always_comb begin
        ext_value = rsp_data;
        case (rsp_id)
            INSTR_LB:  ext_value = {{(XLEN-8){byte_v[7]}}, byte_v};
            INSTR_LBU: ext_value = {{(XLEN-8){1'b0}}, byte_v};
            INSTR_LH:  ext_value = {{(XLEN-16){half_v[15]}}, half_v};
            INSTR_LHU: ext_value = {{(XLEN-16){1'b0}}, half_v};
            default:   ext_value = rsp_data;
        endcase
    end

    // NOTE: entry storage has no reset; occupancy is defined solely by count, so stale slots are never observed.
    always_ff @(posedge clk) begin
        if (enq) begin
            e_is_load[tail]  <= is_load_in;
            e_rd_valid[tail] <= rd_valid_in;
            e_rd_addr[tail]  <= rd_addr_in;
            e_value[tail]    <= rd_value_in;
            e_instr_id[tail] <= instr_id_in;
            e_addr_lo[tail]  <= addr_lo_in;
            e_done[tail]     <= !is_load_in;
        end
        if (rsp_acc) begin
            e_value[rsp_idx] <= ext_value;
            e_done[rsp_idx]  <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            wr_en_out    <= 1'b0;
            rd_addr_out  <= '0;
            rd_value_out <= '0;
            rsp_err      <= 1'b0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop) begin
                wr_en_out    <= e_rd_valid[head] && (e_rd_addr[head] != 5'd0);
                rd_addr_out  <= e_rd_addr[head];
                rd_value_out <= e_value[head];
            end else begin
                wr_en_out <= 1'b0;
            end
            if (rsp_valid && !rsp_found) rsp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_retire_queue.sv
// Self-checking bench for writeback_retire_queue: directed scenarios plus random traffic,
// all compared against a queue-based program-order reference model.
module tb_writeback_retire_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    localparam logic [5:0] ADD  = 6'd1;
    localparam logic [5:0] ADDI = 6'd2;
    localparam logic [5:0] LB   = 6'd3;
    localparam logic [5:0] LH   = 6'd4;
    localparam logic [5:0] LW   = 6'd5;
    localparam logic [5:0] LBU  = 6'd6;
    localparam logic [5:0] LHU  = 6'd7;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            rd_valid_in;
    logic [4:0]      rd_addr_in;
    logic [XLEN-1:0] rd_value_in;
    logic [5:0]      instr_id_in;
    logic [1:0]      addr_lo_in;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            wr_en_out;
    logic [4:0]      rd_addr_out;
    logic [XLEN-1:0] rd_value_out;
    logic            rsp_err;

    writeback_retire_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .rd_valid_in(rd_valid_in), .rd_addr_in(rd_addr_in), .rd_value_in(rd_value_in),
        .instr_id_in(instr_id_in), .addr_lo_in(addr_lo_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .wr_en_out(wr_en_out), .rd_addr_out(rd_addr_out), .rd_value_out(rd_value_out),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_load;
        bit          rd_valid;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [5:0]  id;
        logic [1:0]  lo;
        bit          done;
    } ent_t;

    ent_t        mq[$];
    bit          m_wr_en;
    logic [4:0]  m_rd;
    logic [31:0] m_val;
    bit          m_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [5:0] id_pool [7];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_load_id(input logic [5:0] id);
        return id == LB || id == LH || id == LW || id == LBU || id == LHU;
    endfunction

    function automatic logic [31:0] extract(input logic [5:0] id, input logic [1:0] lo, input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * int'(lo))) & 32'hFF;
        h = (d >> (16 * int'(lo[1]))) & 32'hFFFF;
        case (id)
            LB:      return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            LBU:     return b;
            LH:      return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            LHU:     return h;
            default: return d;
        endcase
    endfunction

    // One clock cycle: drive inputs, check handshake outputs, advance model, check registered outputs.
    task automatic step(input bit iv, input bit rv, input logic [4:0] ra, input logic [31:0] val,
                        input logic [5:0] id, input logic [1:0] lo, input bit sv, input logic [31:0] sd);
        bit   exp_ir, head_done;
        int   ti;
        ent_t e;
        in_valid = iv; rd_valid_in = rv; rd_addr_in = ra; rd_value_in = val;
        instr_id_in = id; addr_lo_in = lo; rsp_valid = sv; rsp_data = sd;
        #1;
        exp_ir = (mq.size() < DEPTH);
        ti = -1;
        for (int i = 0; i < mq.size(); i++)
            if (ti < 0 && mq[i].is_load && !mq[i].done) ti = i;
        check("in_ready", in_ready, exp_ir);
        check("rsp_ready", rsp_ready, ti >= 0);
        head_done = (mq.size() > 0) && mq[0].done;
        if (sv) begin
            if (ti >= 0) begin
                e = mq[ti];
                e.val  = extract(e.id, e.lo, sd);
                e.done = 1'b1;
                mq[ti] = e;
            end else begin
                m_err = 1'b1;
            end
        end
        if (head_done) begin
            e = mq.pop_front();
            m_wr_en = e.rd_valid && (e.rd != 5'd0);
            m_rd    = e.rd;
            m_val   = e.val;
        end else begin
            m_wr_en = 1'b0;
        end
        if (iv && exp_ir) begin
            e.is_load = is_load_id(id); e.rd_valid = rv; e.rd = ra; e.val = val;
            e.id = id; e.lo = lo; e.done = !is_load_id(id);
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
        check("wr_en_out", wr_en_out, m_wr_en);
        check("rd_addr_out", rd_addr_out, m_rd);
        check("rd_value_out", rd_value_out, m_val);
        check("rsp_err", rsp_err, m_err);
    endtask

    task automatic idle();
        step(0, 0, 5'd0, 32'd0, ADD, 2'd0, 0, 32'd0);
    endtask

    task automatic rsp(input logic [31:0] d);
        step(0, 0, 5'd0, 32'd0, ADD, 2'd0, 1, d);
    endtask

    task automatic model_reset();
        mq.delete();
        m_wr_en = 1'b0; m_rd = 5'd0; m_val = 32'd0; m_err = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_wr_en", wr_en_out, 1'b0);
        check("rst_rd_addr", rd_addr_out, 5'd0);
        check("rst_rd_value", rd_value_out, 32'd0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_rsp_ready", rsp_ready, 1'b0);
    endtask

    initial begin
        id_pool[0] = ADD; id_pool[1] = ADDI; id_pool[2] = LB; id_pool[3] = LH;
        id_pool[4] = LW;  id_pool[5] = LBU;  id_pool[6] = LHU;
        rst = 1'b1;
        in_valid = 0; rd_valid_in = 0; rd_addr_in = 0; rd_value_in = 0;
        instr_id_in = 0; addr_lo_in = 0; rsp_valid = 0; rsp_data = 0;
        model_reset();
        #2;
        check_reset_outputs();
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // ADD x5 = 0x11 into an empty queue
        step(1, 1, 5'd5, 32'h11, ADD, 2'd0, 0, 32'd0);
        idle();
        check("t1_wr_en", wr_en_out, 1'b1);
        check("t1_rd", rd_addr_out, 5'd5);
        check("t1_val", rd_value_out, 32'h11);

        // LB x6 offset 2, response two cycles later with ADDI x7 queued behind it
        step(1, 1, 5'd6, 32'd0, LB, 2'd2, 0, 32'd0);
        idle();
        step(1, 1, 5'd7, 32'd3, ADDI, 2'd0, 1, 32'h0080_0000);
        idle();
        check("t2_x6", rd_value_out, 32'hFFFF_FF80);
        check("t2_x6_rd", rd_addr_out, 5'd6);
        idle();
        check("t2_x7", rd_value_out, 32'd3);
        check("t2_x7_rd", rd_addr_out, 5'd7);

        // Half/word extraction from the same raw word
        step(1, 1, 5'd8, 32'd0, LHU, 2'd2, 0, 32'd0);
        rsp(32'hBEEF_1234);
        idle();
        check("t3_lhu", rd_value_out, 32'h0000_BEEF);
        step(1, 1, 5'd8, 32'd0, LH, 2'd3, 0, 32'd0);
        rsp(32'hBEEF_1234);
        idle();
        check("t3_lh", rd_value_out, 32'hFFFF_BEEF);
        step(1, 1, 5'd8, 32'd0, LW, 2'd1, 0, 32'd0);
        rsp(32'hBEEF_1234);
        idle();
        check("t3_lw", rd_value_out, 32'hBEEF_1234);

        // Fill with loads, then back-to-back responses drain in order
        for (int i = 0; i < DEPTH; i++) step(1, 1, 5'(10 + i), 32'd0, LW, 2'd0, 0, 32'd0);
        step(1, 1, 5'd20, 32'd0, ADD, 2'd0, 0, 32'd0);
        check("t4_full", in_ready, 1'b0);
        for (int i = 1; i <= DEPTH; i++) rsp(32'(i));
        idle();
        idle();

        // Write to x0 is suppressed; a response with nothing pending is an error
        step(1, 1, 5'd0, 32'h55, ADD, 2'd0, 0, 32'd0);
        idle();
        check("t5_x0", wr_en_out, 1'b0);
        rsp(32'h1);
        check("t5_err", rsp_err, 1'b1);
        idle();
        check("t5_err_sticky", rsp_err, 1'b1);

        // Asynchronous reset mid-cycle with loads pending
        for (int i = 0; i < 3; i++) step(1, 1, 5'(1 + i), 32'd0, LB, 2'd0, 0, 32'd0);
        in_valid = 0; rsp_valid = 0;
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs();
        #2 rst = 1'b0;
        @(posedge clk); #1;
        rsp(32'hFF);
        check("t6_err", rsp_err, 1'b1);

        // Random traffic against the model
        rst = 1'b1; #1; model_reset(); #1 rst = 1'b0;
        @(posedge clk); #1;
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) < 6, $urandom_range(0, 3) != 0, 5'($urandom),
                 $urandom, id_pool[$urandom_range(0, 6)], 2'($urandom),
                 $urandom_range(0, 9) < 4, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
